maxpool2d_file: RTL and testbench

//   Downstream stage of conv2d_file. Reads the conv output tensor (NCHW, row-major) over the

---
 rtl/pool_pkg.sv | 25 ++
 rtl/pool_addr_gen.sv | 104 ++++++++++
 rtl/maxpool2d_file.sv | 154 +++++++++++++++
 tb/tb_maxpool2d_file.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the max-pool stage and its neighbours.
//   pool_state_e : sequencer states (IDLE/READ/WRITE/DONE)
//   pool_out_dim : output edge length of a pooling/conv window sweep
//   pool_n_out   : number of output elements of an NCHW tensor
// ---------------------------------------------------------------------------
package pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_e;

  function automatic int pool_out_dim(input int in_dim, input int pool, input int stride);
    return (in_dim - pool) / stride + 1;
  endfunction

  function automatic int pool_n_out(input int batch, input int ch, input int out_h, input int out_w);
    return batch * ch * out_h * out_w;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// ---------------------------------------------------------------------------
// pool_addr_gen
// Nested b/c/oh/ow (output) and kh/kw (tap) counters with the read and write
// address arithmetic of the max-pool stage. All arithmetic is ADDR_WIDTH bits.
// Ports:
//   clk         in  clock
//   rst         in  asynchronous active-low reset, clears all counters
//   i_tap_step  in  advance kw (kh on kw wrap); tap counters wrap after last tap
//   i_out_step  in  advance ow/oh/c/b; wraps to zero after the last output
//   o_rd_addr   out input-tensor address of the current tap
//   o_wr_addr   out linear index of the current output (b,c,oh,ow)
//   o_first_tap out current tap is (0,0)
//   o_last_tap  out current tap is (P-1,P-1)
//   o_last_out  out current output is the final one of the tensor
// ---------------------------------------------------------------------------
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int BATCH_SIZE  = 1,
  parameter int CHANNELS    = 1,
  parameter int IN_HEIGHT   = 2,
  parameter int IN_WIDTH    = 2,
  parameter int POOL_SIZE   = 2,
  parameter int POOL_STRIDE = 2,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tap_step,
  input  logic                  i_out_step,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_first_tap,
  output logic                  o_last_tap,
  output logic                  o_last_out
);

  localparam int OUT_H = pool_out_dim(IN_HEIGHT, POOL_SIZE, POOL_STRIDE);
  localparam int OUT_W = pool_out_dim(IN_WIDTH, POOL_SIZE, POOL_STRIDE);

  localparam logic [ADDR_WIDTH-1:0] L_CH     = ADDR_WIDTH'(CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] L_IH     = ADDR_WIDTH'(IN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] L_IW     = ADDR_WIDTH'(IN_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] L_S      = ADDR_WIDTH'(POOL_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] L_OH     = ADDR_WIDTH'(OUT_H);
  localparam logic [ADDR_WIDTH-1:0] L_OW     = ADDR_WIDTH'(OUT_W);
  localparam logic [ADDR_WIDTH-1:0] L_B_MAX  = ADDR_WIDTH'(BATCH_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] L_C_MAX  = ADDR_WIDTH'(CHANNELS - 1);
  localparam logic [ADDR_WIDTH-1:0] L_OH_MAX = ADDR_WIDTH'(OUT_H - 1);
  localparam logic [ADDR_WIDTH-1:0] L_OW_MAX = ADDR_WIDTH'(OUT_W - 1);
  localparam logic [ADDR_WIDTH-1:0] L_P_MAX  = ADDR_WIDTH'(POOL_SIZE - 1);

  logic [ADDR_WIDTH-1:0] r_b, r_c, r_oh, r_ow, r_kh, r_kw;
  logic [ADDR_WIDTH-1:0] w_plane;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_b  <= '0;
      r_c  <= '0;
      r_oh <= '0;
      r_ow <= '0;
      r_kh <= '0;
      r_kw <= '0;
    end else begin
      // kw is the inner tap loop, kh the outer one
      if (i_tap_step) begin
        if (r_kw == L_P_MAX) begin
          r_kw <= '0;
          r_kh <= (r_kh == L_P_MAX) ? '0 : r_kh + 1'b1;
        end else begin
          r_kw <= r_kw + 1'b1;
        end
      end
      // ow fastest, then oh, c, b
      if (i_out_step) begin
        if (r_ow == L_OW_MAX) begin
          r_ow <= '0;
          if (r_oh == L_OH_MAX) begin
            r_oh <= '0;
            if (r_c == L_C_MAX) begin
              r_c <= '0;
              r_b <= (r_b == L_B_MAX) ? '0 : r_b + 1'b1;
            end else begin
              r_c <= r_c + 1'b1;
            end
          end else begin
            r_oh <= r_oh + 1'b1;
          end
        end else begin
          r_ow <= r_ow + 1'b1;
        end
      end
    end
  end

  assign w_plane     = r_b * L_CH + r_c;
  assign o_rd_addr   = (w_plane * L_IH + r_oh * L_S + r_kh) * L_IW + r_ow * L_S + r_kw;
  assign o_wr_addr   = (w_plane * L_OH + r_oh) * L_OW + r_ow;
  assign o_first_tap = (r_kh == '0) && (r_kw == '0);
  assign o_last_tap  = (r_kh == L_P_MAX) && (r_kw == L_P_MAX);
  assign o_last_out  = (r_b == L_B_MAX) && (r_c == L_C_MAX) &&
                       (r_oh == L_OH_MAX) && (r_ow == L_OW_MAX);

endmodule

// File: rtl/maxpool2d_file.sv
// ---------------------------------------------------------------------------
// maxpool2d_file
// 2-D max-pool over an NCHW tensor held in a word-addressed memory; results
// are written to a second memory. One tap is read per cycle, then one write.
// Optional feature macro: POOL_RELU_EN (fused ReLU on the pooled value).
// Ports:
//   clk          in  rising-edge clock
//   rst          in  asynchronous active-low reset (aborts any operation)
//   start        in  start request, sampled only in IDLE
//   done         out 1-cycle pulse after the last write
//   valid        out high in each write cycle
//   input_addr   out read address into the input memory
//   input_data   in  read data, combinational from input_addr
//   input_en     out read enable
//   output_addr  out pooled-tensor write address
//   output_data  out pooled value
//   output_we    out write enable
//   output_en    out output memory enable
// ---------------------------------------------------------------------------
module maxpool2d_file
  import pool_pkg::*;
#(
  parameter int BATCH_SIZE  = 1,
  parameter int CHANNELS    = 1,
  parameter int IN_HEIGHT   = 2,
  parameter int IN_WIDTH    = 2,
  parameter int POOL_SIZE   = 2,
  parameter int POOL_STRIDE = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_en,
  output logic [ADDR_WIDTH-1:0] output_addr,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_we,
  output logic                  output_en
);

  pool_state_e           r_state;
  logic                  r_done;
  logic                  r_we;
  logic                  r_input_en;
  logic [ADDR_WIDTH-1:0] r_output_addr;
  logic [DATA_WIDTH-1:0] r_output_data;
  logic [DATA_WIDTH-1:0] r_max;

  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_first_tap;
  logic                  w_last_tap;
  logic                  w_last_out;
  logic [DATA_WIDTH-1:0] w_max_next;
  logic [DATA_WIDTH-1:0] w_out_val;

  pool_addr_gen #(
    .BATCH_SIZE  (BATCH_SIZE),
    .CHANNELS    (CHANNELS),
    .IN_HEIGHT   (IN_HEIGHT),
    .IN_WIDTH    (IN_WIDTH),
    .POOL_SIZE   (POOL_SIZE),
    .POOL_STRIDE (POOL_STRIDE),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_tap_step  (r_state == ST_READ),
    .i_out_step  (r_state == ST_WRITE),
    .o_rd_addr   (w_rd_addr),
    .o_wr_addr   (w_wr_addr),
    .o_first_tap (w_first_tap),
    .o_last_tap  (w_last_tap),
    .o_last_out  (w_last_out)
  );

  // Tap 0 seeds the max; strict '>' keeps the earlier tap on ties.
  always_comb begin
    w_max_next = r_max;
    if (w_first_tap || ($signed(input_data) > $signed(r_max))) begin
      w_max_next = input_data;
    end
  end

`ifdef POOL_RELU_EN
  assign w_out_val = w_max_next[DATA_WIDTH-1] ? '0 : w_max_next;
`else
  assign w_out_val = w_max_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_done        <= 1'b0;
      r_we          <= 1'b0;
      r_input_en    <= 1'b0;
      r_output_addr <= '0;
      r_output_data <= '0;
      r_max         <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_READ;
            r_input_en <= 1'b1;
          end
        end
        ST_READ: begin
          r_max <= w_max_next;
          if (w_last_tap) begin
            // The final tap's compare result goes straight to the write register
            r_state       <= ST_WRITE;
            r_input_en    <= 1'b0;
            r_we          <= 1'b1;
            r_output_addr <= w_wr_addr;
            r_output_data <= w_out_val;
          end
        end
        ST_WRITE: begin
          r_we          <= 1'b0;
          r_output_addr <= '0;
          r_output_data <= '0;
          if (w_last_out) begin
            r_state <= ST_DONE;
          end else begin
            r_state    <= ST_READ;
            r_input_en <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done        = r_done;
  assign valid       = r_we;
  assign output_we   = r_we;
  assign output_en   = r_we;
  assign input_en    = r_input_en;
  assign input_addr  = r_input_en ? w_rd_addr : '0;
  assign output_addr = r_output_addr;
  assign output_data = r_output_data;

endmodule

// File: tb/tb_maxpool2d_file.sv
// ---------------------------------------------------------------------------
// tb_maxpool2d_file
// Two instances: [0] 1x1x4x4 P=S=2, [1] 2x2x5x5 P=3 S=1 (overlapping windows).
// A window-level reference computes every pooled value; a cycle model of the
// start/READ/WRITE/done timeline drives a per-cycle compare of all outputs.
// ---------------------------------------------------------------------------
module tb_maxpool2d_file;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int PB[2]  = '{1, 2};
  localparam int PC[2]  = '{1, 2};
  localparam int PIH[2] = '{4, 5};
  localparam int PIW[2] = '{4, 5};
  localparam int PP[2]  = '{2, 3};
  localparam int PS[2]  = '{2, 1};
  localparam logic [DW-1:0] SENT = 32'h5A5A_5A5A;

`ifdef POOL_RELU_EN
  localparam int EXP_W1 = 0;
  localparam int EXP_W3 = 0;
`else
  localparam int EXP_W1 = -3;
  localparam int EXP_W3 = -1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] start_v = 2'b00;
  logic [1:0] done_v, valid_v, in_en_v, we_v, en_v;
  logic [AW-1:0] in_addr_v [2];
  logic [AW-1:0] out_addr_v [2];
  logic [DW-1:0] in_data_v [2];
  logic [DW-1:0] out_data_v [2];

  logic [DW-1:0] imem [2][128];
  logic [DW-1:0] omem [2][64];
  logic [DW-1:0] exp_d [2][64];
  int wr_count [2] = '{0, 0};

  logic [1:0] busy = 2'b00;
  logic [1:0] done_e = 2'b00;
  int n_cyc [2] = '{0, 0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maxpool2d_file #(
    .BATCH_SIZE(1), .CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4),
    .POOL_SIZE(2), .POOL_STRIDE(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .done(done_v[0]), .valid(valid_v[0]),
    .input_addr(in_addr_v[0]), .input_data(in_data_v[0]), .input_en(in_en_v[0]),
    .output_addr(out_addr_v[0]), .output_data(out_data_v[0]),
    .output_we(we_v[0]), .output_en(en_v[0])
  );

  maxpool2d_file #(
    .BATCH_SIZE(2), .CHANNELS(2), .IN_HEIGHT(5), .IN_WIDTH(5),
    .POOL_SIZE(3), .POOL_STRIDE(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .done(done_v[1]), .valid(valid_v[1]),
    .input_addr(in_addr_v[1]), .input_data(in_data_v[1]), .input_en(in_en_v[1]),
    .output_addr(out_addr_v[1]), .output_data(out_data_v[1]),
    .output_we(we_v[1]), .output_en(en_v[1])
  );

  // Combinational read memories
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_data_v[i] = '0;
      if (in_en_v[i] && (in_addr_v[i] < 16'd128)) in_data_v[i] = imem[i][in_addr_v[i][6:0]];
    end
  end

  // Write memories, one line per write transaction
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we_v[i] && out_addr_v[i] < 16'd64) begin
        omem[i][out_addr_v[i][5:0]] <= out_data_v[i];
        wr_count[i] <= wr_count[i] + 1;
        $display("inst %0d write addr %0d data %0d", i, out_addr_v[i], $signed(out_data_v[i]));
      end
    end
  end

  function automatic int oh_of(input int i); return (PIH[i] - PP[i]) / PS[i] + 1; endfunction
  function automatic int ow_of(input int i); return (PIW[i] - PP[i]) / PS[i] + 1; endfunction
  function automatic int nout_of(input int i); return PB[i] * PC[i] * oh_of(i) * ow_of(i); endfunction
  function automatic int lat_of(input int i); return PP[i] * PP[i] + 1; endfunction

  // Window-level reference: max over each window, in b,c,oh,ow order
  function automatic void compute_exp(input int i);
    int k, m, v, a;
    k = 0;
    for (int b = 0; b < PB[i]; b++)
      for (int c = 0; c < PC[i]; c++)
        for (int oh = 0; oh < oh_of(i); oh++)
          for (int ow = 0; ow < ow_of(i); ow++) begin
            m = 0;
            for (int kh = 0; kh < PP[i]; kh++)
              for (int kw = 0; kw < PP[i]; kw++) begin
                a = ((b * PC[i] + c) * PIH[i] + oh * PS[i] + kh) * PIW[i] + ow * PS[i] + kw;
                v = int'(imem[i][a]);
                if ((kh == 0 && kw == 0) || v > m) m = v;
              end
`ifdef POOL_RELU_EN
            if (m < 0) m = 0;
`endif
            exp_d[i][k] = m;
            k++;
          end
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d t=%0t", nm, i, $signed(act), $signed(req), $time);
    end
  endtask

  // Timeline model: cycle n after the start-sampling edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        busy[i] <= 1'b0;
        done_e[i] <= 1'b0;
        n_cyc[i] <= 0;
      end else begin
        done_e[i] <= 1'b0;
        if (busy[i]) begin
          n_cyc[i] <= n_cyc[i] + 1;
          if (n_cyc[i] + 1 == nout_of(i) * lat_of(i) + 1) begin
            busy[i] <= 1'b0;
            done_e[i] <= 1'b1;
          end
        end else if (start_v[i]) begin
          busy[i] <= 1'b1;
          n_cyc[i] <= 0;
        end
      end
    end
  end

  // Per-cycle compare
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int k, r, ow, oh, c, b, kh, kw, e_addr, e_oaddr;
      logic e_en, e_val, e_done;
      logic [DW-1:0] e_data;
      e_en = 1'b0; e_val = 1'b0; e_done = 1'b0; e_addr = 0; e_oaddr = 0; e_data = '0;
      if (rst) begin
        e_done = done_e[i];
        if (busy[i] && n_cyc[i] < nout_of(i) * lat_of(i)) begin
          k = n_cyc[i] / lat_of(i);
          r = n_cyc[i] % lat_of(i);
          ow = k % ow_of(i);
          oh = (k / ow_of(i)) % oh_of(i);
          c  = (k / (ow_of(i) * oh_of(i))) % PC[i];
          b  = k / (ow_of(i) * oh_of(i) * PC[i]);
          if (r < PP[i] * PP[i]) begin
            kh = r / PP[i];
            kw = r % PP[i];
            e_en = 1'b1;
            e_addr = ((b * PC[i] + c) * PIH[i] + oh * PS[i] + kh) * PIW[i] + ow * PS[i] + kw;
          end else begin
            e_val = 1'b1;
            e_oaddr = k;
            e_data = exp_d[i][k];
          end
        end
      end
      chk("input_en", i, 32'(in_en_v[i]), 32'(e_en));
      chk("valid", i, 32'(valid_v[i]), 32'(e_val));
      chk("output_we", i, 32'(we_v[i]), 32'(e_val));
      chk("output_en", i, 32'(en_v[i]), 32'(e_val));
      chk("done", i, 32'(done_v[i]), 32'(e_done));
      if (e_en || !rst) chk("input_addr", i, 32'(in_addr_v[i]), 32'(e_addr));
      if (e_val || !rst) begin
        chk("output_addr", i, 32'(out_addr_v[i]), 32'(e_oaddr));
        chk("output_data", i, out_data_v[i], e_data);
      end
    end
  end

  // Runs one operation on instance i; returns the cycle index where done was seen
  task automatic run(input int i, input bit extra, output int dcyc);
    int nl;
    int base;
    nl = nout_of(i) * lat_of(i);
    compute_exp(i);
    base = wr_count[i];
    @(posedge clk); #2 start_v[i] = 1'b1;
    @(posedge clk); #2 start_v[i] = 1'b0;
    dcyc = -1;
    for (int n = 1; n <= nl + 4 && dcyc < 0; n++) begin
      @(posedge clk); #2;
      // Extra starts land in READ/WRITE, and one lands in the DONE cycle
      start_v[i] = extra && ((n < nl - 1 && $urandom_range(0, 3) == 0) || n == nl);
      #4;
      if (done_v[i]) dcyc = n;
    end
    start_v[i] = 1'b0;
    chk("done_seen", i, 32'(dcyc >= 0), 32'd1);
    @(posedge clk); #2;
    chk("write_count", i, wr_count[i] - base, nout_of(i));
    for (int k = 0; k < nout_of(i); k++) chk("omem", i, omem[i][k], exp_d[i][k]);
    $display("inst %0d run complete, done at cycle %0d", i, dcyc);
  endtask

  task automatic fill_sent(input int i);
    for (int k = 0; k < 64; k++) omem[i][k] = SENT;
  endtask

  initial begin
    int d;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 128; k++) imem[i][k] = '0;
    fill_sent(0);
    fill_sent(1);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_done", 0, 32'(done_v[0]), 32'd0);
    chk("reset_valid", 1, 32'(valid_v[1]), 32'd0);
    @(negedge clk); #2 rst = 1'b1;

    // Windows: chain values, all-negative, ties, negative max
    begin
      int pat[16];
      pat = '{84, 100, -5, -3, 148, 164, -9, -7, 7, 7, -1, -8, 7, 7, -2, -4};
      for (int k = 0; k < 16; k++) imem[0][k] = DW'(pat[k]);
    end
    run(0, 1'b0, d);
    chk("lit_chain", 0, omem[0][0], 32'd164);
    chk("lit_neg", 0, omem[0][1], EXP_W1);
    chk("lit_tie", 0, omem[0][2], 32'd7);
    chk("lit_negmax", 0, omem[0][3], EXP_W3);
    chk("lit_done21", 0, d, 21);

    // input[i] = i
    for (int k = 0; k < 16; k++) imem[0][k] = DW'(k);
    run(0, 1'b0, d);
    chk("lit_ramp0", 0, omem[0][0], 32'd5);
    chk("lit_ramp1", 0, omem[0][1], 32'd7);
    chk("lit_ramp2", 0, omem[0][2], 32'd13);
    chk("lit_ramp3", 0, omem[0][3], 32'd15);
    chk("lit_done21b", 0, d, 21);

    // Same, with start pulsed during the run and in the DONE cycle
    fill_sent(0);
    run(0, 1'b1, d);
    chk("lit_ramp_ign", 0, omem[0][3], 32'd15);
    chk("lit_done21c", 0, d, 21);

    // Abort during the second write
    fill_sent(0);
    compute_exp(0);
    @(posedge clk); #2 start_v[0] = 1'b1;
    @(posedge clk); #2 start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("abort_pre_valid", 0, 32'(valid_v[0]), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_valid", 0, 32'(valid_v[0]), 32'd0);
    chk("abort_data", 0, out_data_v[0], 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    chk("abort_m0", 0, omem[0][0], 32'd5);
    chk("abort_m1", 0, omem[0][1], SENT);
    chk("abort_m2", 0, omem[0][2], SENT);
    chk("abort_m3", 0, omem[0][3], SENT);
    run(0, 1'b0, d);
    chk("rerun_done", 0, d, 21);
    chk("rerun_m1", 0, omem[0][1], 32'd7);

    // Randomized runs on both instances
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++)
        imem[0][k] = (r == 1) ? DW'(int'($urandom_range(0, 6)) - 3) : DW'($urandom);
      run(0, r == 2, d);
      chk("rand_done0", 0, d, 21);
      for (int k = 0; k < 100; k++)
        imem[1][k] = (r == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 15)) - 8);
      run(1, r == 1, d);
      chk("rand_done1", 1, d, 361);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
